// File: rtl/tlb_assoc.sv
// Fully-associative Sv39 TLB with ASID tagging, global pages and sfence-style flush.
// Define TLB_SUPERPAGE_EN to enable 2M/1G superpages; otherwise every entry is a 4K page.
module tlb_assoc #(
    parameter int LG_N   = 3,
    parameter int ASID_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              flush,
    input  logic              flush_use_va,
    input  logic              flush_use_asid,
    input  logic [63:0]       flush_va,
    input  logic [ASID_W-1:0] flush_asid,
    input  logic              active,
    input  logic              req,
    input  logic [63:0]       va,
    input  logic [ASID_W-1:0] asid,
    output logic              hit,
    output logic [63:0]       pa,
    output logic              dirty,
    output logic              readable,
    output logic              writable,
    output logic              executable,
    output logic              user,
    input  logic              replace,
    input  logic [63:0]       replace_va,
    input  logic [63:0]       replace_pa,
    input  logic [ASID_W-1:0] replace_asid,
    input  logic              replace_global,
    input  logic [1:0]        replace_level,
    input  logic              replace_dirty,
    input  logic              replace_readable,
    input  logic              replace_writable,
    input  logic              replace_executable,
    input  logic              replace_user
);
    localparam int N = 1 << LG_N;

    logic [N-1:0]      valid_q, global_q, dirty_q, read_q, write_q, exec_q, user_q;
    logic [26:0]       vpn_q  [N];
    logic [51:0]       ppn_q  [N];
    logic [ASID_W-1:0] asid_q [N];
    logic [1:0]        lvl_e  [N];
    logic [LG_N-1:0]   victim_q;

    logic [N-1:0]      look_match, fill_match, flush_hit;
    logic [LG_N-1:0]   look_idx, fill_idx;
    logic              use_victim;
    logic [63:0]       look_pa;
    logic              unused_bits;

`ifdef TLB_SUPERPAGE_EN
    logic [1:0] level_q [N];
    always_comb for (int unsigned i = 0; i < N; i++) lvl_e[i] = level_q[i];
    assign unused_bits = ^{flush_va[63:39], flush_va[11:0], replace_va[63:39],
                           replace_va[11:0], replace_pa[11:0]};
`else
    always_comb for (int unsigned i = 0; i < N; i++) lvl_e[i] = 2'd0;
    assign unused_bits = ^{flush_va[63:39], flush_va[11:0], replace_va[63:39],
                           replace_va[11:0], replace_pa[11:0], replace_level};
`endif

    // VPN bits that take part in the compare for a given page level
    function automatic logic [26:0] vpn_mask(input logic [1:0] level);
        case (level)
            2'd1:    vpn_mask = {18'h3ffff, 9'h0};
            2'd2:    vpn_mask = {9'h1ff, 18'h0};
            default: vpn_mask = '1;
        endcase
    endfunction

    function automatic logic [LG_N-1:0] first_set(input logic [N-1:0] v);
        first_set = '0;
        for (int unsigned i = N; i > 0; i--)
            if (v[i-1]) first_set = LG_N'(i - 1);
    endfunction

    always_comb begin
        look_match = '0;
        fill_match = '0;
        flush_hit  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            look_match[i] = valid_q[i] & (global_q[i] | (asid_q[i] == asid)) &
                            (((va[38:12] ^ vpn_q[i]) & vpn_mask(lvl_e[i])) == '0);
            fill_match[i] = valid_q[i] & (global_q[i] | (asid_q[i] == replace_asid)) &
                            (((replace_va[38:12] ^ vpn_q[i]) & vpn_mask(lvl_e[i])) == '0);
            flush_hit[i]  = valid_q[i] &
                            (!flush_use_va |
                             (((flush_va[38:12] ^ vpn_q[i]) & vpn_mask(lvl_e[i])) == '0)) &
                            (!flush_use_asid | (!global_q[i] & (asid_q[i] == flush_asid)));
        end
    end

    always_comb begin
        look_idx   = first_set(look_match);
        use_victim = 1'b0;
        if (|fill_match)    fill_idx = first_set(fill_match);
        else if (~&valid_q) fill_idx = first_set(~valid_q);
        else begin
            fill_idx   = victim_q;
            use_victim = 1'b1;
        end
        case (lvl_e[look_idx])
            2'd2:    look_pa = {ppn_q[look_idx][51:18], va[29:0]};
            2'd1:    look_pa = {ppn_q[look_idx][51:9], va[20:0]};
            default: look_pa = {ppn_q[look_idx], va[11:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            victim_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= valid_q & ~flush_hit;
        end else if (replace) begin
            valid_q[fill_idx]  <= 1'b1;
            vpn_q[fill_idx]    <= replace_va[38:12];
            ppn_q[fill_idx]    <= replace_pa[63:12];
            asid_q[fill_idx]   <= replace_asid;
            global_q[fill_idx] <= replace_global;
            dirty_q[fill_idx]  <= replace_dirty;
            read_q[fill_idx]   <= replace_readable;
            write_q[fill_idx]  <= replace_writable;
            exec_q[fill_idx]   <= replace_executable;
            user_q[fill_idx]   <= replace_user;
`ifdef TLB_SUPERPAGE_EN
            level_q[fill_idx]  <= (replace_level == 2'd3) ? 2'd0 : replace_level;
`endif
            if (use_victim) victim_q <= victim_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit        <= 1'b0;
            pa         <= '0;
            dirty      <= 1'b0;
            readable   <= 1'b0;
            writable   <= 1'b0;
            executable <= 1'b0;
            user       <= 1'b0;
        end else if (!active) begin
            hit        <= 1'b1;
            pa         <= va;
            dirty      <= 1'b1;
            readable   <= 1'b1;
            writable   <= 1'b1;
            executable <= 1'b1;
            user       <= 1'b0;
        end else begin
            hit        <= req & (|look_match);
            pa         <= look_pa;
            dirty      <= dirty_q[look_idx];
            readable   <= read_q[look_idx];
            writable   <= write_q[look_idx];
            executable <= exec_q[look_idx];
            user       <= user_q[look_idx];
        end
    end
endmodule

// File: tb/tb_tlb_assoc.sv
// Self-checking bench for tlb_assoc: directed scenarios plus randomized traffic
// compared against an arithmetic page-table-entry model.
module tb_tlb_assoc;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset, clear, flush, flush_use_va, flush_use_asid;
    logic [63:0] flush_va;
    logic [15:0] flush_asid;
    logic        active, req;
    logic [63:0] va;
    logic [15:0] asid;
    logic        hit;
    logic [63:0] pa;
    logic        dirty, readable, writable, executable, user;
    logic        replace;
    logic [63:0] replace_va, replace_pa;
    logic [15:0] replace_asid;
    logic        replace_global;
    logic [1:0]  replace_level;
    logic [4:0]  replace_perm;   // {dirty, readable, writable, executable, user}

    int checks = 0;
    int errors = 0;

    tlb_assoc #(.LG_N(3), .ASID_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .flush(flush),
        .flush_use_va(flush_use_va), .flush_use_asid(flush_use_asid),
        .flush_va(flush_va), .flush_asid(flush_asid),
        .active(active), .req(req), .va(va), .asid(asid),
        .hit(hit), .pa(pa), .dirty(dirty), .readable(readable),
        .writable(writable), .executable(executable), .user(user),
        .replace(replace), .replace_va(replace_va), .replace_pa(replace_pa),
        .replace_asid(replace_asid), .replace_global(replace_global),
        .replace_level(replace_level),
        .replace_dirty(replace_perm[4]), .replace_readable(replace_perm[3]),
        .replace_writable(replace_perm[2]), .replace_executable(replace_perm[1]),
        .replace_user(replace_perm[0])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [38:0] base;
        logic [63:0] pa;
        logic [15:0] asid;
        logic        g;
        int          lvl;
        logic [4:0]  perm;
    } ent_t;

    ent_t m[N];
    int   vic;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_va_hit(input int i, input logic [63:0] v);
        int sh = 12 + 9 * m[i].lvl;
        return (v[38:0] >> sh) == (m[i].base >> sh);
    endfunction

    function automatic int m_find(input logic [63:0] v, input logic [15:0] a);
        for (int i = 0; i < N; i++)
            if (m[i].v && (m[i].g || m[i].asid == a) && m_va_hit(i, v)) return i;
        return -1;
    endfunction

    function automatic logic [63:0] m_pa(input int i, input logic [63:0] v);
        int sh = 12 + 9 * m[i].lvl;
        logic [63:0] lowmask = (64'd1 << sh) - 64'd1;
        return (m[i].pa & ~lowmask) | (v & lowmask);
    endfunction

    task automatic m_update();
        int slot;
        if (reset) begin
            for (int i = 0; i < N; i++) m[i].v = 1'b0;
            vic = 0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) m[i].v = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < N; i++)
                if ((!flush_use_va || m_va_hit(i, flush_va)) &&
                    (!flush_use_asid || (!m[i].g && m[i].asid == flush_asid)))
                    m[i].v = 1'b0;
        end else if (replace) begin
            slot = m_find(replace_va, replace_asid);
            if (slot < 0)
                for (int i = N - 1; i >= 0; i--) if (!m[i].v) slot = i;
            if (slot < 0) begin
                slot = vic;
                vic  = (vic + 1) % N;
            end
            m[slot].v    = 1'b1;
            m[slot].base = replace_va[38:0];
            m[slot].pa   = replace_pa;
            m[slot].asid = replace_asid;
            m[slot].g    = replace_global;
            m[slot].perm = replace_perm;
`ifdef TLB_SUPERPAGE_EN
            m[slot].lvl  = (replace_level == 2'd3) ? 0 : int'(replace_level);
`else
            m[slot].lvl  = 0;
`endif
        end
    endtask

    // Expected result comes from the pre-edge model state; the model then advances.
    task automatic do_cycle();
        logic        e_hit = 1'b0;
        logic [63:0] e_pa = '0;
        logic [4:0]  e_perm = '0;
        bit          full = 1'b1;
        int          idx;
        if (reset) begin
            e_hit = 1'b0;
        end else if (!active) begin
            e_hit = 1'b1; e_pa = va; e_perm = 5'b11110;
        end else begin
            idx   = m_find(va, asid);
            e_hit = req && (idx >= 0);
            full  = e_hit;
            if (e_hit) begin
                e_pa   = m_pa(idx, va);
                e_perm = m[idx].perm;
            end
        end
        @(posedge clk);
        #1;
        m_update();
        check("hit", hit, e_hit);
        if (full) begin
            check("pa", pa, e_pa);
            check("perm", {dirty, readable, writable, executable, user}, e_perm);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; clear = 0; flush = 0; replace = 0; req = 0;
    endtask

    task automatic fill(input logic [63:0] v, input logic [63:0] p, input logic [15:0] a,
                        input logic g, input logic [1:0] lvl, input logic [4:0] perm);
        replace = 1; replace_va = v; replace_pa = p; replace_asid = a;
        replace_global = g; replace_level = lvl; replace_perm = perm;
        do_cycle();
        replace = 0;
    endtask

    task automatic look(input logic [63:0] v, input logic [15:0] a);
        req = 1; va = v; asid = a;
        do_cycle();
        req = 0;
    endtask

    task automatic do_flush(input logic use_va, input logic use_asid,
                            input logic [63:0] v, input logic [15:0] a);
        flush = 1; flush_use_va = use_va; flush_use_asid = use_asid;
        flush_va = v; flush_asid = a;
        do_cycle();
        flush = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) m[i] = '{v: 1'b0, base: '0, pa: '0, asid: '0, g: 1'b0, lvl: 0, perm: '0};
        vic = 0;
        idle_inputs();
        active = 1; flush_use_va = 0; flush_use_asid = 0; flush_va = '0; flush_asid = '0;
        va = '0; asid = '0; replace_va = '0; replace_pa = '0; replace_asid = '0;
        replace_global = 0; replace_level = '0; replace_perm = '0;

        reset = 1; do_cycle(); reset = 0;
        check("reset_pa", pa, 64'h0);

        // translate a 4K page, then ASID isolation and global refill
        fill(64'h4000_1000, 64'h8000_5000, 16'd1, 1'b0, 2'd0, 5'b01100);
        look(64'h4000_1abc, 16'd1);
        check("t1_hit", hit, 1); check("t1_pa", pa, 64'h8000_5abc); check("t1_w", writable, 1);
        look(64'h4000_1abc, 16'd2);
        check("t2_asid_miss", hit, 0);
        fill(64'h4000_1000, 64'h8000_5000, 16'd1, 1'b1, 2'd0, 5'b01100);
        look(64'h4000_1abc, 16'd2);
        check("t2_global_hit", hit, 1);

`ifdef TLB_SUPERPAGE_EN
        fill(64'h4020_0000, 64'h9000_0000, 16'd1, 1'b0, 2'd1, 5'b01010);
        look(64'h403f_f123, 16'd1);
        check("t3_2m_hit", hit, 1); check("t3_2m_pa", pa, 64'h901f_f123);
        fill(64'h8000_0000, 64'h1_4000_0000, 16'd1, 1'b0, 2'd2, 5'b01000);
        look(64'h8abc_def0, 16'd1);
        check("t3_1g_hit", hit, 1); check("t3_1g_pa", pa, 64'h1_4abc_def0);
`endif

        // N+2 fills into an empty TLB: the two oldest are evicted
        clear = 1; do_cycle(); clear = 0;
        for (int k = 0; k < N + 2; k++)
            fill(64'(k + 1) << 12, 64'h7000_0000 + (64'(k) << 12), 16'd3, 1'b0, 2'd0, 5'b01000);
        for (int k = 0; k < N + 2; k++) begin
            look((64'(k + 1) << 12) | 64'h5, 16'd3);
            check($sformatf("t4_page%0d", k), hit, (k >= 2) ? 1 : 0);
        end

        // selective flush by ASID, then by VA, then clear beating replace
        clear = 1; do_cycle(); clear = 0;
        fill(64'h1000, 64'hA000, 16'd1, 1'b0, 2'd0, 5'b01000);
        fill(64'h2000, 64'hB000, 16'd1, 1'b1, 2'd0, 5'b01000);
        fill(64'h3000, 64'hC000, 16'd2, 1'b0, 2'd0, 5'b01000);
        do_flush(1'b0, 1'b1, 64'h0, 16'd1);
        look(64'h1000, 16'd1); check("t5_asid_flushed", hit, 0);
        look(64'h2000, 16'd1); check("t5_global_kept", hit, 1);
        look(64'h3000, 16'd2); check("t5_other_kept", hit, 1);
        do_flush(1'b1, 1'b0, 64'h2000, 16'd0);
        look(64'h2000, 16'd1); check("t5_va_flushed", hit, 0);
        look(64'h3000, 16'd2); check("t5_va_other_kept", hit, 1);
        clear = 1;
        fill(64'h5000, 64'hD000, 16'd2, 1'b0, 2'd0, 5'b01000);
        clear = 0;
        look(64'h5000, 16'd2); check("t5_clear_wins", hit, 0);
        look(64'h3000, 16'd2); check("t5_cleared", hit, 0);

        // bare mode and reset mid-stream
        active = 0; look(64'h1234, 16'd0);
        check("t6_bare_hit", hit, 1); check("t6_bare_pa", pa, 64'h1234);
        active = 1;
        fill(64'h6000, 64'hE000, 16'd2, 1'b0, 2'd0, 5'b11111);
        reset = 1; req = 1; replace = 1; va = 64'h6000; asid = 16'd2;
        do_cycle();
        idle_inputs();
        check("t6_reset_hit", hit, 0); check("t6_reset_pa", pa, 64'h0);

        // randomized traffic over a small VA pool so hits, overlaps and evictions occur
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 199) == 0);
            clear   = ($urandom_range(0, 99) < 2);
            flush   = ($urandom_range(0, 99) < 8);
            replace = ($urandom_range(0, 99) < 40);
            active  = ($urandom_range(0, 99) < 92);
            req     = ($urandom_range(0, 99) < 85);
            va      = (64'($urandom_range(0, 1)) << 30) | (64'($urandom_range(0, 3)) << 21) |
                      (64'($urandom_range(0, 3)) << 12) | 64'($urandom_range(0, 4095));
            asid    = 16'($urandom_range(1, 2));
            flush_use_va   = $urandom_range(0, 1) != 0;
            flush_use_asid = $urandom_range(0, 1) != 0;
            flush_va       = (64'($urandom_range(0, 1)) << 30) | (64'($urandom_range(0, 3)) << 21) |
                             (64'($urandom_range(0, 3)) << 12);
            flush_asid     = 16'($urandom_range(1, 2));
            replace_va     = (64'($urandom_range(0, 1)) << 30) | (64'($urandom_range(0, 3)) << 21) |
                             (64'($urandom_range(0, 3)) << 12) | 64'($urandom_range(0, 4095));
            replace_pa     = {$urandom, $urandom};
            replace_asid   = 16'($urandom_range(1, 2));
            replace_global = ($urandom_range(0, 99) < 20);
            replace_level  = 2'($urandom_range(0, 3));
            replace_perm   = 5'($urandom);
            do_cycle();
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
